// File: rtl/bsg_cache_sbuf_pkg.sv
// Shared encodings for the two-entry store-buffer control stage: occupancy
// count values and the datapath mux select meanings.
package bsg_cache_sbuf_pkg;

    localparam logic [1:0] sbuf_empty = 2'd0;
    localparam logic [1:0] sbuf_one   = 2'd1;
    localparam logic [1:0] sbuf_full  = 2'd2;

    localparam logic sel_data_in = 1'b0;
    localparam logic sel_el0     = 1'b1;

    typedef enum logic [1:0] {
        cnt_empty = sbuf_empty,
        cnt_one   = sbuf_one,
        cnt_full  = sbuf_full
    } sbuf_count_e;

endpackage

// File: rtl/bsg_cache_sbuf_ctrl_if.sv
// Store-in / retire-out handshake bundle of the store-buffer control stage.
// Store side: a store moves when v_i & ready_o on a clock edge; ready_o never
// depends on v_i or yumi_i. Retire side: head moves when v_o & yumi_i; yumi_i
// may only be raised while v_o is high and may depend combinationally on v_o.
interface bsg_cache_sbuf_ctrl_if #(parameter int addr_width_p = 32) ();

    logic                    v_i;
    logic [addr_width_p-1:0] addr_i;
    logic                    ready_o;
    logic                    v_o;
    logic [addr_width_p-1:0] addr_o;
    logic                    yumi_i;

    modport master (output v_i, addr_i, yumi_i, input ready_o, v_o, addr_o);
    modport slave  (input v_i, addr_i, yumi_i, output ready_o, v_o, addr_o);

endinterface

// File: rtl/bsg_cache_sbuf_addr_match.sv
// Load-bypass address comparator for the two store-buffer entries; the newer
// entry (el0) takes priority when both entries match.
module bsg_cache_sbuf_addr_match #(
    parameter int addr_width_p = 32
) (
    input  logic                    el0_v,
    input  logic                    el1_v,
    input  logic [addr_width_p-1:0] el0_addr,
    input  logic [addr_width_p-1:0] el1_addr,
    input  logic [addr_width_p-1:0] bypass_addr,
    output logic                    hit,
    output logic                    sel
);

    logic m0;
    logic m1;

    assign m1  = el1_v & (el1_addr == bypass_addr);
    assign m0  = el0_v & (el0_addr == bypass_addr);
    assign hit = m0 | m1;
    // sel=1 points at el1; any el0 match overrides because el0 is newer.
    assign sel = ~m0;

endmodule

// File: rtl/bsg_cache_sbuf_ctrl.sv
// Control and address tracking for the two-element store-buffer datapath.
// Optional zero-latency pass-through when empty: BSG_CACHE_SBUF_CTRL_FALLTHRU_EN.
module bsg_cache_sbuf_ctrl
    import bsg_cache_sbuf_pkg::*;
#(
    parameter int addr_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bsg_cache_sbuf_ctrl_if.slave    sbuf_if,
    output logic                    el0_en_o,
    output logic                    el1_en_o,
    output logic                    mux0_sel_o,
    output logic                    mux1_sel_o,
    input  logic [addr_width_p-1:0] bypass_addr_i,
    output logic                    bypass_hit_o,
    output logic                    bypass_sel_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [1:0]              count_o
);

    sbuf_count_e             count_r, count_n;
    logic [addr_width_p-1:0] el0_addr_r;
    logic [addr_width_p-1:0] el1_addr_r;
    logic                    enq, deq, pass;

    // Full never accepts, even alongside a retire, so ready has no yumi path.
    assign sbuf_if.ready_o = (count_r != cnt_full);
    assign empty_o         = (count_r == cnt_empty);
    assign full_o          = (count_r == cnt_full);
    assign count_o         = count_r;
    assign mux1_sel_o      = (count_r != cnt_empty);

`ifdef BSG_CACHE_SBUF_CTRL_FALLTHRU_EN
    assign sbuf_if.v_o    = empty_o ? sbuf_if.v_i    : 1'b1;
    assign sbuf_if.addr_o = empty_o ? sbuf_if.addr_i : el1_addr_r;
    assign pass           = empty_o & enq & deq;
`else
    assign sbuf_if.v_o    = ~empty_o;
    assign sbuf_if.addr_o = el1_addr_r;
    assign pass           = 1'b0;
`endif

    assign enq = sbuf_if.v_i & sbuf_if.ready_o;
    assign deq = sbuf_if.yumi_i & sbuf_if.v_o;

    always_comb begin
        count_n    = count_r;
        el0_en_o   = 1'b0;
        el1_en_o   = 1'b0;
        mux0_sel_o = sel_data_in;
        case (count_r)
            cnt_empty: begin
                if (enq && !pass) begin
                    el1_en_o = 1'b1;
                    count_n  = cnt_one;
                end
            end
            cnt_one: begin
                if (enq && deq) begin
                    el1_en_o = 1'b1;
                end else if (enq) begin
                    el0_en_o = 1'b1;
                    count_n  = cnt_full;
                end else if (deq) begin
                    count_n  = cnt_empty;
                end
            end
            cnt_full: begin
                if (deq) begin
                    el1_en_o   = 1'b1;
                    mux0_sel_o = sel_el0;
                    count_n    = cnt_one;
                end
            end
            default: count_n = cnt_empty;
        endcase
    end

    // Shadow addresses follow exactly the writes the datapath performs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r    <= cnt_empty;
            el0_addr_r <= '0;
            el1_addr_r <= '0;
        end else begin
            count_r <= count_n;
            if (el0_en_o) el0_addr_r <= sbuf_if.addr_i;
            if (el1_en_o) el1_addr_r <= (mux0_sel_o == sel_el0) ? el0_addr_r : sbuf_if.addr_i;
        end
    end

    bsg_cache_sbuf_addr_match #(.addr_width_p(addr_width_p)) u_addr_match (
        .el0_v       (count_r == cnt_full),
        .el1_v       (count_r != cnt_empty),
        .el0_addr    (el0_addr_r),
        .el1_addr    (el1_addr_r),
        .bypass_addr (bypass_addr_i),
        .hit         (bypass_hit_o),
        .sel         (bypass_sel_o)
    );

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        sbuf_if.yumi_i |-> sbuf_if.v_o);

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Bench for bsg_cache_sbuf_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a queue model (BSG_CACHE_SBUF_CTRL_FALLTHRU_EN aware).
module tb_bsg_cache_sbuf_ctrl;

    localparam int W = 32;
`ifdef BSG_CACHE_SBUF_CTRL_FALLTHRU_EN
    localparam bit ft = 1'b1;
`else
    localparam bit ft = 1'b0;
`endif

    // clock / reset
    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bsg_cache_sbuf_ctrl_if #(.addr_width_p(W)) bus ();
    logic         el0_en, el1_en, mux0_sel, mux1_sel;
    logic [W-1:0] bypass_addr;
    logic         hit, sel, empty, full;
    logic [1:0]   count;

    bsg_cache_sbuf_ctrl #(.addr_width_p(W)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .sbuf_if      (bus),
        .el0_en_o     (el0_en),
        .el1_en_o     (el1_en),
        .mux0_sel_o   (mux0_sel),
        .mux1_sel_o   (mux1_sel),
        .bypass_addr_i(bypass_addr),
        .bypass_hit_o (hit),
        .bypass_sel_o (sel),
        .empty_o      (empty),
        .full_o       (full),
        .count_o      (count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: head of queue is the oldest store (el1), back is the newest
    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           next_id = 0;

    always @(negedge clk_i) begin
        int           n;
        bit           exp_vo, enq, deq, pass, m0, m1, e1, e0, mx0;
        logic [W-1:0] nq[$];
        int           nid[$];
        if (!reset_n_i) begin
            exp_q.delete();
            id_q.delete();
            chk("rst_ready", bus.ready_o, 1);
            chk("rst_v_o", bus.v_o, ft & bus.v_i);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_hit", hit, 0);
            chk("rst_count", count, 0);
        end else begin
            n      = exp_q.size();
            exp_vo = (n != 0) || (ft && bus.v_i);
            enq    = bus.v_i && (n != 2);
            deq    = bus.yumi_i && exp_vo;
            pass   = ft && (n == 0) && enq && deq;
            chk("ready", bus.ready_o, n != 2);
            chk("v_o", bus.v_o, exp_vo);
            if (exp_vo) chk("addr_o", bus.addr_o, (n != 0) ? exp_q[0] : bus.addr_i);
            chk("mux1_sel", mux1_sel, n != 0);
            chk("empty", empty, n == 0);
            chk("full", full, n == 2);
            chk("count", count, n);
            m1 = (n >= 1) && (exp_q[0] == bypass_addr);
            m0 = (n == 2) && (exp_q[1] == bypass_addr);
            chk("bypass_hit", hit, m0 | m1);
            chk("bypass_sel", sel, !m0);
            nq  = exp_q;
            nid = id_q;
            if (deq && !pass) begin
                void'(nq.pop_front());
                void'(nid.pop_front());
            end
            if (enq && !pass) begin
                nq.push_back(bus.addr_i);
                nid.push_back(next_id);
            end
            // el1 is written whenever a different store becomes the head
            e1  = (nid.size() > 0) && ((n == 0) || (nid[0] != id_q[0]));
            mx0 = e1 && (nid[0] != next_id);
            e0  = (nid.size() == 2) && (nid[1] == next_id) && enq;
            chk("el1_en", el1_en, e1);
            chk("el0_en", el0_en, e0);
            chk("mux0_sel", mux0_sel, mx0);
            if (enq) next_id++;
            exp_q = nq;
            id_q  = nid;
        end
    end

    // driver: inputs change 1 time unit after posedge, checks happen after negedge
    task automatic cyc(input logic v, input logic [W-1:0] a, input logic y, input logic [W-1:0] b);
        @(posedge clk_i); #1;
        bus.v_i     = v;
        bus.addr_i  = a;
        bus.yumi_i  = y;
        bypass_addr = b;
        @(negedge clk_i); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) cyc(0, 0, 1, 0);
    endtask

    initial begin
        bus.v_i = 0; bus.addr_i = 0; bus.yumi_i = 0; bypass_addr = 0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("lit_rst_ready", bus.ready_o, 1);
        chk("lit_rst_v_o", bus.v_o, 0);
        chk("lit_rst_en", {el0_en, el1_en, mux0_sel}, 0);
        @(posedge clk_i); #1; reset_n_i = 1;

        cyc(1, 32'h100, 0, 0);
        chk("lit_enq1_el1_en", el1_en, 1);
        chk("lit_enq1_mux0", mux0_sel, 0);
        cyc(0, 0, 0, 0);
        chk("lit_enq1_v_o", bus.v_o, 1);
        chk("lit_enq1_addr", bus.addr_o, 32'h100);
        cyc(1, 32'h200, 0, 0);
        chk("lit_enq2_el0_en", el0_en, 1);
        cyc(1, 32'h300, 0, 0);
        chk("lit_full", full, 1);
        chk("lit_full_ready", bus.ready_o, 0);
        chk("lit_full_noen", {el0_en, el1_en}, 0);
        cyc(0, 0, 1, 0);
        chk("lit_deq_el1_en", el1_en, 1);
        chk("lit_deq_mux0", mux0_sel, 1);
        cyc(0, 0, 0, 0);
        chk("lit_deq_addr", bus.addr_o, 32'h200);
        chk("lit_deq_count", count, 1);
        cyc(1, 32'h300, 1, 0);
        cyc(0, 0, 0, 0);
        chk("lit_swap_count", count, 1);
        chk("lit_swap_addr", bus.addr_o, 32'h300);
        drain();

        cyc(1, 32'h40, 0, 0);
        cyc(1, 32'h40, 0, 0);
        cyc(0, 0, 0, 32'h40);
        chk("lit_byp_both_hit", hit, 1);
        chk("lit_byp_both_sel", sel, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 32'h80, 0, 0);
        cyc(0, 0, 0, 32'h40);
        chk("lit_byp_el1_hit", hit, 1);
        chk("lit_byp_el1_sel", sel, 1);
        cyc(0, 0, 0, 32'h44);
        chk("lit_byp_miss", hit, 0);
        drain();

        cyc(1, 32'h10, ft, 0);
        chk("lit_ft_v_o", bus.v_o, ft);
        cyc(0, 0, 0, 0);
        chk("lit_ft_count", count, ft ? 0 : 1);
        drain();

        for (int i = 0; i < 800; i++) begin
            logic         v, y;
            logic [W-1:0] a, b;
            if ($urandom_range(0, 149) == 0) begin
                @(posedge clk_i); #1;
                bus.v_i = 0; bus.yumi_i = 0; reset_n_i = 0;
                @(posedge clk_i); #1;
                reset_n_i = 1;
                @(negedge clk_i); #1;
            end
            v = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: a = 32'h40;
                1: a = 32'h44;
                2: a = 32'h80;
                default: a = $urandom;
            endcase
            y = ((exp_q.size() != 0) || (ft && v)) ? ($urandom_range(0, 1) == 1) : 1'b0;
            case ($urandom_range(0, 3))
                0: b = (exp_q.size() > 0) ? exp_q[0] : 32'h40;
                1: b = (exp_q.size() > 1) ? exp_q[1] : 32'h80;
                2: b = 32'h44;
                default: b = $urandom;
            endcase
            cyc(v, a, y, b);
        end
        cyc(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_cache_sbuf_ctrl.md
Name: bsg_cache_sbuf_ctrl

Overview:
Control and address-tracking stage that directly drives the two-element store-buffer datapath queue (el0 = tail, el1 = head).
- Accepts stores with a valid/ready handshake and retires them with a valid/yumi handshake.
- Generates el0_en, el1_en, mux0_sel and mux1_sel for the datapath.
- Keeps a shadow copy of each entry's address so load bypass can be answered by address match.

Parameters:
addr_width_p, 32, width of the store address tracked per entry.

Ports:
clk_i  in  1  clock; all state updates on posedge.
reset_n_i  in  1  asynchronous, active-low reset.
v_i  in  1  incoming store valid.
addr_i  in  addr_width_p  incoming store address.
ready_o  out  1  can accept a store.
v_o  out  1  head entry valid toward the cache.
addr_o  out  addr_width_p  head entry address.
yumi_i  in  1  consumer takes head this cycle; legal only when v_o=1.
el0_en_o  out  1  datapath el0 write enable.
el1_en_o  out  1  datapath el1 write enable.
mux0_sel_o  out  1  1 selects el0 into el1; 0 selects data_i into el1.
mux1_sel_o  out  1  1 selects el1 as data_o; 0 selects data_i.
bypass_addr_i  in  addr_width_p  load address to snoop.
bypass_hit_o  out  1  some valid entry matches bypass_addr_i.
bypass_sel_o  out  1  matching entry to use: 1 = el1, 0 = el0.
empty_o  out  1  count==0.
full_o  out  1  count==2.

Behaviour:
- State: count_r in {0,1,2} (2 bits); el0_addr_r and el1_addr_r.
- Reset (async assert, sync deassert handled upstream): count_r=0, both addr regs=0. After reset: ready_o=1, v_o=0, empty_o=1, full_o=0, bypass_hit_o=0, all enables 0.
- Definitions: enq = v_i & ready_o; deq = yumi_i & v_o.
- ready_o = (count_r != 2). A full queue does not accept a store even when deq occurs the same cycle; this avoids a yumi->ready combinational path.
- v_o = (count_r != 0). addr_o = el1_addr_r. mux1_sel_o = (count_r != 0).
- Transitions; default el0_en=el1_en=mux0_sel=0:
  - count 0, enq: el1_en=1, mux0_sel=0; el1_addr<=addr_i; count->1.
  - count 1, enq only: el0_en=1; el0_addr<=addr_i; count->2.
  - count 1, deq only: count->0; address regs unchanged.
  - count 1, enq & deq: el1_en=1, mux0_sel=0; el1_addr<=addr_i; count stays 1.
  - count 2, deq: el1_en=1, mux0_sel=1; el1_addr<=el0_addr; count->1.
  - count 2 with v_i: store is not accepted (ready_o=0).
- Store latency: one cycle from accept to v_o.
- Illegal inputs: yumi_i while v_o=0 is ignored and flagged by assertion. v_i while ready_o=0 leaves state untouched.
- Bypass match: m1 = (count>=1) & (el1_addr==bypass_addr_i); m0 = (count==2) & (el0_addr==bypass_addr_i).
  - bypass_hit_o = m0 | m1.
  - bypass_sel_o = ~m0, so the newer entry el0 wins when both match.
  - Purely combinational on current state; same-cycle enq is not visible.
- Reset mid-operation: all entries are dropped immediately; no retire occurs.

Optional Feature:
Macro: BSG_CACHE_SBUF_CTRL_FALLTHRU_EN.
- Defined, empty case: v_o = v_i, addr_o = addr_i, mux1_sel_o=0 (data_i passes to data_o). enq & deq at count 0 leaves count at 0 with no register write. ready_o behaviour is unchanged.
- Undefined: v_o=0 whenever count=0 and there is no zero-latency path.

Decomposition:
- Package bsg_cache_sbuf_pkg: count encoding localparams (sbuf_empty=0, sbuf_one=1, sbuf_full=2) and the mux select localparams (sel_data_in=0, sel_el0=1).
- One natural sub-module: bsg_cache_sbuf_addr_match, holding the two comparators plus the newest-wins priority (outputs hit, sel).
- Top level contains the count FSM and the address registers.

Test Plan:
- Reset with v_i=0: ready_o=1, v_o=0, empty_o=1. Release reset, enq addr 0x100: next cycle v_o=1, addr_o=0x100, el1_en=1 and mux0_sel=0 during the enq cycle.
- Enq 0x100 then 0x200 with no yumi: full_o=1, ready_o=0. A third v_i 0x300 is not accepted and state is unchanged.
- At full, pulse yumi_i: el1_en=1, mux0_sel=1; next cycle addr_o=0x200, count=1.
- At count=1, enq 0x300 and yumi_i in the same cycle: count stays 1, next addr_o=0x300.
- Full with el1=0x40 and el0=0x40, bypass_addr_i=0x40: hit=1, sel=0. Set el0=0x80: sel=1. Bypass 0x44: hit=0.
- With BSG_CACHE_SBUF_CTRL_FALLTHRU_EN, empty, v_i=1 addr 0x10 and yumi_i=1: v_o=1, addr_o=0x10, mux1_sel=0, count stays 0. Without the macro, v_o=0 in the same scenario.
